// File: rtl/vram_pkg.sv
// vram_pkg: framebuffer geometry, RGB332 field positions and the rectangle-writer FSM encoding.
package vram_pkg;
    localparam int FB_WIDTH  = 160;
    localparam int FB_HEIGHT = 120;
    localparam int ADDR_W    = 15;
    localparam int RED_MSB   = 7;
    localparam int RED_LSB   = 5;
    localparam int GRN_MSB   = 4;
    localparam int GRN_LSB   = 2;
    localparam int BLU_MSB   = 1;
    localparam int BLU_LSB   = 0;
    typedef enum logic [1:0] {IDLE, SETUP, WRITE, DONE} wr_state_e;
endpackage

// File: rtl/rect_scan_counter.sv
// rect_scan_counter: row-major pixel walker over a clipped rectangle.
// Exposes the address of the pixel it will hold after this edge, so the caller can register it directly.
module rect_scan_counter
    import vram_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              en_i,
    input  logic [7:0]        x0_i,
    input  logic [6:0]        y0_i,
    input  logic [ADDR_W-1:0] base0_i,
    input  logic [8:0]        x_end_i,
    input  logic [7:0]        y_end_i,
    output logic [ADDR_W-1:0] addr_next_o,
    output logic              last_o
);
    logic [7:0]        x_q, x_d;
    logic [6:0]        y_q, y_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              row_end;

    always_comb begin
        row_end     = ({1'b0, x_q} + 9'd1) == x_end_i;
        last_o      = row_end && (({1'b0, y_q} + 8'd1) == y_end_i);
        x_d         = load_i ? x0_i : (en_i ? (row_end ? x0_i : x_q + 8'd1) : x_q);
        y_d         = load_i ? y0_i : (en_i && row_end ? y_q + 7'd1 : y_q);
        base_d      = load_i ? base0_i : (en_i && row_end ? base_q + ADDR_W'(FB_WIDTH) : base_q);
        addr_next_o = base_d + ADDR_W'(x_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q    <= '0;
            y_q    <= '0;
            base_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            base_q <= base_d;
        end
    end
endmodule

// File: rtl/vram_rect_writer.sv
// vram_rect_writer: clips one rectangle-fill command to the framebuffer and streams row-major VRAM writes.
// Define VRAM_RECT_VBLANK_ONLY_EN to restrict writes to cycles with vblank high.
module vram_rect_writer
    import vram_pkg::*;
(
    input  logic              clock_25mhz,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_x,
    input  logic [6:0]        cmd_y,
    input  logic [7:0]        cmd_w,
    input  logic [6:0]        cmd_h,
    input  logic [7:0]        cmd_color,
    input  logic              vblank,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_waddr,
    output logic [7:0]        vram_wdata,
    output logic              busy,
    output logic              done
);
    wr_state_e         state_q, state_d;
    logic [7:0]        cx_q, cw_q, color_q, wdata_q, wdata_d, rgb;
    logic [6:0]        cy_q, ch_q;
    logic [8:0]        x_sum, x_end_q, x_end_d;
    logic [7:0]        y_sum, y_end_q, y_end_d;
    logic [ADDR_W-1:0] base0, addr_next, waddr_q, waddr_d;
    logic              we_q, we_d, load, en, last, fire, empty;

`ifdef VRAM_RECT_VBLANK_ONLY_EN
    assign fire    = vblank;
    assign vram_we = we_q & vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign fire          = 1'b1;
    assign vram_we       = we_q;
`endif

    always_comb begin
        x_sum   = {1'b0, cx_q} + {1'b0, cw_q};
        x_end_d = x_sum > 9'(FB_WIDTH) ? 9'(FB_WIDTH) : x_sum;
        y_sum   = {1'b0, cy_q} + {1'b0, ch_q};
        y_end_d = y_sum > 8'(FB_HEIGHT) ? 8'(FB_HEIGHT) : y_sum;
        base0   = ADDR_W'(cy_q) * ADDR_W'(FB_WIDTH);
        empty   = cx_q >= 8'(FB_WIDTH) || cy_q >= 7'(FB_HEIGHT) || cw_q == 8'd0 || ch_q == 7'd0;
        rgb     = {color_q[RED_MSB:RED_LSB], color_q[GRN_MSB:GRN_LSB], color_q[BLU_MSB:BLU_LSB]};
    end

    // Counter loads in SETUP so the first write is already registered on entry to WRITE.
    assign load = state_q == SETUP && !empty;
    assign en   = state_q == WRITE && fire && !last;

    rect_scan_counter u_scan (
        .clk_i       (clock_25mhz),
        .rst_ni      (reset_n),
        .load_i      (load),
        .en_i        (en),
        .x0_i        (cx_q),
        .y0_i        (cy_q),
        .base0_i     (base0),
        .x_end_i     (x_end_q),
        .y_end_i     (y_end_q),
        .addr_next_o (addr_next),
        .last_o      (last)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE:  state_d = cmd_valid ? SETUP : IDLE;
            SETUP: begin
                we_d    = !empty;
                waddr_d = empty ? waddr_q : addr_next;
                wdata_d = empty ? wdata_q : rgb;
                state_d = empty ? DONE : WRITE;
            end
            WRITE: if (fire) begin
                we_d    = !last;
                waddr_d = last ? waddr_q : addr_next;
                state_d = last ? DONE : WRITE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            cw_q    <= '0;
            ch_q    <= '0;
            color_q <= '0;
            x_end_q <= '0;
            y_end_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            if (state_q == IDLE && cmd_valid) begin
                cx_q    <= cmd_x;
                cy_q    <= cmd_y;
                cw_q    <= cmd_w;
                ch_q    <= cmd_h;
                color_q <= cmd_color;
            end
            if (state_q == SETUP) begin
                x_end_q <= x_end_d;
                y_end_q <= y_end_d;
            end
        end
    end

    assign cmd_ready  = state_q == IDLE;
    assign busy       = state_q != IDLE;
    assign done       = state_q == DONE;
    assign vram_waddr = waddr_q;
    assign vram_wdata = wdata_q;
endmodule

// File: tb/tb_vram_rect_writer.sv
// tb_vram_rect_writer: scoreboard bench; expected writes are queued at command acceptance and popped per vram_we.
module tb_vram_rect_writer;
    logic        clock_25mhz = 1'b0;
    logic        reset_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        vblank = 1'b1;
    logic [7:0]  cmd_x = '0, cmd_w = '0, cmd_color = '0;
    logic [6:0]  cmd_y = '0, cmd_h = '0;
    logic        cmd_ready, vram_we, busy, done;
    logic [14:0] vram_waddr;
    logic [7:0]  vram_wdata;

    typedef struct {int t; int lat;} cmd_t;
    cmd_t cq[$];
    cmd_t cur;
    int   exp_addr[$];
    int   exp_data[$];
    int   errors = 0, checks = 0, cyc = 0, wr_cnt = 0, done_cnt = 0, wr_in_cmd = 0;

    vram_rect_writer dut (
        .clock_25mhz (clock_25mhz),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_w       (cmd_w),
        .cmd_h       (cmd_h),
        .cmd_color   (cmd_color),
        .vblank      (vblank),
        .vram_we     (vram_we),
        .vram_waddr  (vram_waddr),
        .vram_wdata  (vram_wdata),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock_25mhz = ~clock_25mhz;
    always @(posedge clock_25mhz) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clock_25mhz) begin
        if (vram_we) begin
            wr_cnt++;
            check("we_in_vblank", int'(vblank), 1);
            check("addr_range", int'(vram_waddr < 15'd19200), 1);
            if (wr_in_cmd == 0 && cq.size() > 0) check("first_we_lat", cyc - cq[0].t, 2);
            wr_in_cmd++;
            if (exp_addr.size() == 0) check("spurious_we", 1, 0);
            else begin
                check("waddr", int'(vram_waddr), exp_addr.pop_front());
                check("wdata", int'(vram_wdata), exp_data.pop_front());
            end
        end
        if (done) begin
            done_cnt++;
            wr_in_cmd = 0;
            if (cq.size() == 0) check("spurious_done", 1, 0);
            else begin
                cur = cq.pop_front();
                check("done_lat", cyc - cur.t, cur.lat);
                check("writes_left", exp_addr.size(), 0);
            end
        end
    end

    task automatic send(input int x, input int y, input int w, input int h, input int c,
                        input int extra, output int t);
        int k = 0;
        int n = 0;
        t = -1;
        @(negedge clock_25mhz);
        cmd_x = 8'(x); cmd_y = 7'(y); cmd_w = 8'(w); cmd_h = 7'(h); cmd_color = 8'(c);
        cmd_valid = 1'b1;
        while (!cmd_ready && k < 300) begin
            @(negedge clock_25mhz);
            k++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        t = cyc;
        for (int yy = y; yy < y + h && yy < 120; yy++)
            for (int xx = x; xx < x + w && xx < 160; xx++) begin
                exp_addr.push_back(yy * 160 + xx);
                exp_data.push_back(c);
                n++;
            end
        cq.push_back('{cyc, 2 + n + extra});
        @(negedge clock_25mhz);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((cq.size() != 0 || !cmd_ready) && k < 3000) begin
            @(negedge clock_25mhz);
            k++;
        end
        if (k >= 3000) check("idle_timeout", 0, 1);
        @(negedge clock_25mhz);
    endtask

    initial begin
        int ta, tb, t, w0, dc, k;
        #1 reset_n = 1'b0;
        #1;
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_we", int'(vram_we), 0);
        check("rst_waddr", int'(vram_waddr), 0);
        check("rst_wdata", int'(vram_wdata), 0);
        repeat (2) @(negedge clock_25mhz);
        reset_n = 1'b1;

        send(2, 3, 3, 2, 'hE0, 0, t);
        wait_idle();
        check("basic_writes", wr_cnt, 6);
        check("basic_dones", done_cnt, 1);

        send(158, 119, 10, 5, 'h1C, 0, t);
        wait_idle();
        check("clip_writes", wr_cnt, 8);

        send(20, 20, 0, 4, 'h03, 0, t);
        @(negedge clock_25mhz);
        check("empty_done_t2", int'(done), 1);
        check("empty_ready_t2", int'(cmd_ready), 0);
        @(negedge clock_25mhz);
        check("empty_ready_t3", int'(cmd_ready), 1);
        send(160, 5, 4, 4, 'h11, 0, t);
        wait_idle();
        check("empty_writes", wr_cnt, 8);
        check("empty_dones", done_cnt, 4);

        send(0, 0, 4, 1, 'h55, 0, ta);
        send(10, 50, 2, 2, 'hAA, 0, tb);
        check("hold_accept", tb - ta, 7);
        wait_idle();
        check("hold_dones", done_cnt, 6);
        check("hold_writes", wr_cnt, 16);

        for (int i = 0; i < 5; i++) begin
            send($urandom_range(0, 165), $urandom_range(0, 125), $urandom_range(0, 6),
                 $urandom_range(0, 4), $urandom_range(0, 255), 0, t);
            wait_idle();
        end
        check("rand_dones", done_cnt, 11);

        w0 = wr_cnt;
        send(10, 10, 4, 4, 'h77, 0, t);
        k = 0;
        do begin
            @(negedge clock_25mhz);
            #1;
            k++;
        end while (wr_cnt < w0 + 3 && k < 100);
        dc = done_cnt;
        reset_n = 1'b0;
        #1;
        check("abort_we", int'(vram_we), 0);
        check("abort_ready", int'(cmd_ready), 1);
        check("abort_busy", int'(busy), 0);
        exp_addr.delete();
        exp_data.delete();
        cq.delete();
        wr_in_cmd = 0;
        repeat (3) @(negedge clock_25mhz);
        check("abort_no_done", done_cnt, dc);
        check("abort_writes", wr_cnt, w0 + 3);
        reset_n = 1'b1;
        send(100, 100, 3, 3, 'h12, 0, t);
        wait_idle();
        check("post_abort_writes", wr_cnt, w0 + 12);
        check("post_abort_dones", done_cnt, dc + 1);

`ifdef VRAM_RECT_VBLANK_ONLY_EN
        begin
            int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
            w0 = wr_cnt;
            send(5, 5, 4, 1, 'hF0, 3, t);
            for (int i = 0; i < 7; i++) begin
                @(posedge clock_25mhz);
                #1 vblank = pat[i][0];
            end
            @(posedge clock_25mhz);
            #1 vblank = 1'b1;
            wait_idle();
            check("vblank_writes", wr_cnt, w0 + 4);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vram_rect_writer.md
Name: vram_rect_writer

Overview:
- Write-side engine for the 160x120, 8-bit-per-pixel framebuffer VRAM that the VGA scan-out path reads.
- Accepts one rectangle-fill command at a time over a valid/ready handshake.
- Clips the rectangle to the framebuffer and emits one VRAM write per cycle, row-major, at address y*160+x.
- Sits between the CPU/command bus and the VRAM write port.

Parameters:
- FB_WIDTH, 160, framebuffer width in pixels (row stride)
- FB_HEIGHT, 120, framebuffer height in pixels
- ADDR_W, 15, VRAM address width

Ports:
- clock_25mhz  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  engine can accept a command
- cmd_x  input  8  left column
- cmd_y  input  7  top row
- cmd_w  input  8  width in pixels
- cmd_h  input  7  height in pixels
- cmd_color  input  8  RGB332 fill value
- vblank  input  1  high when scan-out is outside the active video area; used only with VBLANK_ONLY_EN
- vram_we  output  1  write strobe
- vram_waddr  output  15  write address
- vram_wdata  output  8  write data
- busy  output  1  command in progress
- done  output  1  one-cycle pulse when a command completes

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE; cmd_ready=1; busy=0; done=0; vram_we=0; vram_waddr=0; vram_wdata=0.
- Asserting reset_n low mid-command aborts immediately. vram_we drops asynchronously, no done pulse, and the partial rectangle stays in VRAM.
- FSM states: IDLE, SETUP, WRITE, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready (cycle T), latch all cmd_* fields and go to SETUP.
- SETUP (T+1):
  - busy=1, cmd_ready=0.
  - x_end = min(cmd_x+cmd_w, FB_WIDTH), computed in 9 bits.
  - y_end = min(cmd_y+cmd_h, FB_HEIGHT), computed in 8 bits.
  - row_base = cmd_y*FB_WIDTH, computed in 15 bits.
  - Empty command (cmd_x>=FB_WIDTH, cmd_y>=FB_HEIGHT, cmd_w==0 or cmd_h==0): go to DONE with zero writes.
  - Otherwise go to WRITE.
- WRITE (first write at T+2):
  - Registered outputs: vram_we=1, vram_waddr=row_base+x, vram_wdata=color.
  - x increments each cycle.
  - At x==x_end-1: x reloads cmd_x, row_base += FB_WIDTH, y increments. No bubble between rows.
  - At x==x_end-1 && y==y_end-1: last write, next state DONE.
- DONE:
  - done=1 for one cycle; vram_we=0.
  - Next state IDLE; cmd_ready returns to 1 the cycle after done.
- Writes per command = (x_end-cmd_x)*(y_end-cmd_y).
- Total latency from accept to done = 2 + writes cycles.
- Commands presented while busy are held by the master (cmd_ready low). No queueing.
- Addresses never exceed FB_WIDTH*FB_HEIGHT-1 (19199).

Optional Feature:
- Macro: VRAM_RECT_VBLANK_ONLY_EN.
- Defined:
  - In WRITE, a write occurs only in cycles with vblank=1.
  - When vblank=0: vram_we=0 and x, y, row_base hold.
  - Resumes at the same pixel when vblank returns high. No pixel is skipped or duplicated.
  - done is delayed accordingly.
- Undefined: vblank is ignored and writes run back-to-back.

Decomposition:
- Shared package vram_pkg:
  - FB_WIDTH, FB_HEIGHT, ADDR_W.
  - RGB332 field positions (red [7:5], green [4:2], blue [1:0]).
  - FSM state typedef/encoding (IDLE, SETUP, WRITE, DONE).
- Sub-module rect_scan_counter:
  - Owns x, y, row_base, advance and last-pixel logic, with an enable input.
  - The top module keeps the FSM, handshake, clipping and output registers.

Test Plan:
- Reset then cmd x=2,y=3,w=3,h=2,color=8'hE0 → 6 writes at addr 482,483,484,642,643,644; data E0; first we at T+2; done at T+8.
- cmd x=158,y=119,w=10,h=5 → clipped to 2 writes at addr 19198,19199; done pulse; no address >19199.
- cmd w=0 (or x=160) → zero writes; done at T+2; cmd_ready high at T+3.
- Second cmd_valid held during busy → not accepted until cmd_ready returns; then executes normally; exactly one done per command.
- reset_n low after 3rd write of a 4x4 fill → vram_we=0 immediately; no done; after release cmd_ready=1 and a new command runs correctly.
- With VRAM_RECT_VBLANK_ONLY_EN, 4x1 fill with vblank toggling 1,0,0,1,1,0,1 → exactly 4 writes at consecutive addresses, only in vblank=1 cycles.
